// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder sequencer
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - combinational 1-bit full adder
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer around one full-adder cell
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("serial_add_ctrl: WIDTH out of range");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               msb_cin_q, msb_cin_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               fa_s, fa_c;

    full_adder_cell u_cell (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .c   (fa_c)
    );

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        msb_cin_d   = msb_cin_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1; the +1 rides in on the carry flop.
                    a_sh_d  = op_a;
                    b_sh_d  = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 2)) begin
                    msb_cin_d = fa_c;
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d       = '0;
                    cout_d      = fa_c;
                    ovf_d       = msb_cin_q ^ fa_c;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            msb_cin_q   <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            msb_cin_q   <= msb_cin_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
